// File: rtl/mtrx_vec_mult.sv
`default_nettype none
// ============================================================================
//  Module   : mtrx_vec_mult
//  Purpose  : Sequential 4x4 matrix by 4-vector multiplier for the vertex
//             transform path. A single shared signed MAC performs one
//             multiply-accumulate per cycle. Each transaction takes 16 cycles.
//             Each row sum is floor-shifted by FRAC and saturated to DW bits.
//  Ports    : clk       - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             mtrx_in   - row-major packed matrix, m11 in the MSBs
//             vec_in    - packed {X,Y,Z,W}, X in the MSBs
//             in_valid  - mtrx_in/vec_in valid
//             in_ready  - block can accept a transaction (IDLE decode)
//             vec_out   - packed result {Xo,Yo,Zo,Wo}
//             out_ovf   - at least one result element saturated
//             out_valid - vec_out/out_ovf valid (DONE decode)
//             out_ready - downstream accepts the result
//  Revision : 1.0 - initial release
// ============================================================================
module mtrx_vec_mult #(
   parameter int DW   = 21,
   parameter int FRAC = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [16*DW-1:0]  mtrx_in,
   input  logic [4*DW-1:0]   vec_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [4*DW-1:0]   vec_out,
   output logic              out_ovf,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PW = 2 * DW;        // full product width
   localparam int AW = 2 * DW + 2;    // accumulator width, holds 4 products

   localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-(64'sd1 <<< (DW - 1)));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [1:0]              row;
   logic [1:0]              col;
   logic [16*DW-1:0]        mtrx_q;
   logic [4*DW-1:0]         vec_q;
   logic signed [AW-1:0]    acc;

   logic [3:0]              m_idx;
   logic [1:0]              v_idx;
   logic [1:0]              r_idx;
   logic [DW-1:0]           m_el;
   logic [DW-1:0]           v_el;
   logic signed [PW-1:0]    m_ext;
   logic signed [PW-1:0]    v_ext;
   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    sum;
   logic signed [AW-1:0]    shifted;
   logic [DW-1:0]           sat_val;
   logic                    sat_hit;

   // Element k = 4*row+col lives at slot (15-k) counting from the LSB end.
   assign m_idx = 4'd15 - {row, col};
   assign v_idx = 2'd3 - col;
   assign r_idx = 2'd3 - row;

   assign m_el  = mtrx_q[m_idx*DW +: DW];
   assign v_el  = vec_q[v_idx*DW +: DW];

   // Operands are sign-extended to the product width, so the multiply is
   // self-determined at the full 2*DW bits.
   assign m_ext = {{DW{m_el[DW-1]}}, m_el};
   assign v_ext = {{DW{v_el[DW-1]}}, v_el};
   assign prod  = m_ext * v_ext;

   assign sum     = acc + {{(AW - PW){prod[PW-1]}}, prod};
   assign shifted = sum >>> FRAC;   // arithmetic shift = floor

   always_comb begin
      sat_hit = 1'b0;
      sat_val = shifted[DW-1:0];
      if (shifted > SAT_MAX) begin
         sat_hit = 1'b1;
         sat_val = SAT_MAX[DW-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_hit = 1'b1;
         sat_val = SAT_MIN[DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         vec_out   <= '0;
         out_ovf   <= 1'b0;
         acc       <= '0;
         row       <= 2'd0;
         col       <= 2'd0;
         mtrx_q    <= '0;
         vec_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mtrx_q   <= mtrx_in;
                  vec_q    <= vec_in;
                  row      <= 2'd0;
                  col      <= 2'd0;
                  acc      <= '0;
                  out_ovf  <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end

            CALC: begin
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  // Row complete: write the scaled, saturated sum and
                  // restart the accumulator for the next row.
                  acc              <= '0;
                  vec_out[r_idx*DW +: DW] <= sat_val;
                  if (sat_hit) begin
                     out_ovf <= 1'b1;
                  end
                  row <= row + 2'd1;
                  if (row == 2'd3) begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  acc <= sum;
               end
            end

            DONE: begin
               // vec_out is intentionally left holding the last result.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_ovf   <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mtrx_vec_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mtrx_vec_mult
//  Purpose  : Directed self-checking bench for mtrx_vec_mult. Expected
//             values are hand-computed Q10 fixed-point results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mtrx_vec_mult;

   localparam int DW = 21;

   logic              clk;
   logic              rst_n;
   logic [16*DW-1:0]  mtrx_in;
   logic [4*DW-1:0]   vec_in;
   logic              in_valid;
   logic              in_ready;
   logic [4*DW-1:0]   vec_out;
   logic              out_ovf;
   logic              out_valid;
   logic              out_ready;

   int total = 0;
   int bad   = 0;

   mtrx_vec_mult #(.DW(21), .FRAC(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mtrx_in   (mtrx_in),
      .vec_in    (vec_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .vec_out   (vec_out),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [83:0] obs, input logic [83:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [335:0] put(input logic [335:0] m, input int k, input logic [20:0] val);
      logic [335:0] t;
      t = m;
      t[(15 - k) * 21 +: 21] = val;
      return t;
   endfunction

   function automatic logic [335:0] rnd336();
      logic [351:0] t;
      for (int i = 0; i < 11; i++) t[i * 32 +: 32] = $urandom;
      return t[335:0];
   endfunction

   function automatic logic [83:0] rnd84();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[83:0];
   endfunction

   // Accepts one transaction, scrambles the inputs every CALC cycle, and
   // returns the number of edges until out_valid (40 = timed out).
   task automatic do_txn(input string tag, input logic [335:0] m, input logic [83:0] v, output int lat);
      check({tag, "_in_ready"}, {83'd0, in_ready}, 84'd1);
      mtrx_in  = m;
      vec_in   = v;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         mtrx_in  = rnd336();
         vec_in   = rnd84();
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, {83'd0, out_valid}, 84'd0);
      check({tag, "_ir_rise"}, {83'd0, in_ready}, 84'd1);
   endtask

   logic [335:0] ident;
   logic [335:0] trans;
   logic [335:0] mtmp;
   logic [83:0]  vtrans;
   logic [83:0]  exp_trans;
   logic [83:0]  held;
   int           lat;

   initial begin
      rst_n     = 1'b0;
      mtrx_in   = '0;
      vec_in    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      ident = '0;
      for (int i = 0; i < 4; i++) ident = put(ident, i * 5, 21'h000400);
      trans = put(ident, 3, 21'h000C00);
      trans = put(trans, 7, 21'h1FF800);
      trans = put(trans, 11, 21'h000200);
      vtrans    = {21'h000400, 21'h000800, 21'h1FFC00, 21'h000400};
      exp_trans = {21'h001000, 21'h000000, 21'h1FFE00, 21'h000400};

      // Reset state
      #12;
      check("rst_in_ready",  {83'd0, in_ready},  84'd1);
      check("rst_out_valid", {83'd0, out_valid}, 84'd0);
      check("rst_vec_out",   vec_out,            84'd0);
      check("rst_out_ovf",   {83'd0, out_ovf},   84'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Translation
      do_txn("trans", trans, vtrans, lat);
      check("trans_latency", 84'(lat), 84'd16);
      check("trans_vec", vec_out, exp_trans);
      check("trans_ovf", {83'd0, out_ovf}, 84'd0);
      handoff("trans");

      // Floor: 1 * 1 LSB -> 0
      mtmp = put('0, 0, 21'h000001);
      do_txn("floor_pos", mtmp, {21'h000001, 63'd0}, lat);
      check("floor_pos_vec", vec_out, 84'd0);
      handoff("floor_pos");

      // Floor: -1 * 1 LSB -> -1
      mtmp = put('0, 0, 21'h1FFFFF);
      do_txn("floor_neg", mtmp, {21'h000001, 63'd0}, lat);
      check("floor_neg_vec", vec_out, {21'h1FFFFF, 63'd0});
      check("floor_neg_ovf", {83'd0, out_ovf}, 84'd0);
      handoff("floor_neg");

      // Positive saturation
      mtmp = put('0, 0, 21'h0FFFFF);
      do_txn("sat_pos", mtmp, {21'h0FFFFF, 63'd0}, lat);
      check("sat_pos_vec", vec_out, {21'h0FFFFF, 63'd0});
      check("sat_pos_ovf", {83'd0, out_ovf}, 84'd1);
      handoff("sat_pos");

      // Negative saturation, then held under backpressure
      mtmp = put('0, 0, 21'h100000);
      do_txn("sat_neg", mtmp, {21'h0FFFFF, 63'd0}, lat);
      check("sat_neg_vec", vec_out, {21'h100000, 63'd0});
      check("sat_neg_ovf", {83'd0, out_ovf}, 84'd1);
      held = {21'h100000, 63'd0};
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         mtrx_in  = rnd336();
         vec_in   = rnd84();
         @(posedge clk); #1;
         check("bp_out_valid", {83'd0, out_valid}, 84'd1);
         check("bp_vec_out",   vec_out,            held);
         check("bp_out_ovf",   {83'd0, out_ovf},   84'd1);
         check("bp_in_ready",  {83'd0, in_ready},  84'd0);
      end
      // in_valid stays high across the handoff edge: no accept may occur.
      in_valid = 1'b1;
      handoff("bp");
      in_valid = 1'b0;
      check("bp_vec_kept", vec_out, held);

      // Clean transaction after saturation clears out_ovf
      do_txn("clean", trans, vtrans, lat);
      check("clean_vec", vec_out, exp_trans);
      check("clean_ovf", {83'd0, out_ovf}, 84'd0);
      handoff("clean");

      // Operand latch with a denser matrix; inputs scrambled during CALC
      mtmp = '0;
      mtmp = put(mtmp, 0,  21'h000800);
      mtmp = put(mtmp, 3,  21'h000400);
      mtmp = put(mtmp, 5,  21'h000200);
      mtmp = put(mtmp, 8,  21'h000400);
      mtmp = put(mtmp, 9,  21'h000400);
      mtmp = put(mtmp, 10, 21'h000400);
      mtmp = put(mtmp, 11, 21'h000400);
      mtmp = put(mtmp, 14, 21'h1FFC00);
      do_txn("latch", mtmp, {21'h000400, 21'h000800, 21'h000C00, 21'h000400}, lat);
      check("latch_latency", 84'(lat), 84'd16);
      check("latch_vec", vec_out, {21'h000C00, 21'h000400, 21'h001C00, 21'h1FF400});
      check("latch_ovf", {83'd0, out_ovf}, 84'd0);
      handoff("latch");

      // Reset at CALC cycle 8
      mtrx_in  = put('0, 0, 21'h0FFFFF);
      vec_in   = {21'h0FFFFF, 63'd0};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  {83'd0, in_ready},  84'd1);
      check("mid_rst_out_valid", {83'd0, out_valid}, 84'd0);
      check("mid_rst_vec_out",   vec_out,            84'd0);
      check("mid_rst_out_ovf",   {83'd0, out_ovf},   84'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_txn("post_rst", trans, vtrans, lat);
      check("post_rst_latency", 84'(lat), 84'd16);
      check("post_rst_vec", vec_out, exp_trans);
      check("post_rst_ovf", {83'd0, out_ovf}, 84'd0);
      handoff("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
